// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared hold levels, bus widths and FSM encodings for pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int Hold_Flag_Bus = 3;
    localparam int INT_BUS       = 8;

    typedef logic [Hold_Flag_Bus-1:0] hold_flag_t;
    typedef logic [INT_BUS-1:0]       int_flag_t;

    localparam hold_flag_t Hold_None = 3'd0;
    localparam hold_flag_t Hold_Pc   = 3'd1;
    localparam hold_flag_t Hold_If   = 3'd2;
    localparam hold_flag_t Hold_Id   = 3'd3;

    localparam int_flag_t INT_NONE = 8'h00;

    localparam logic [0:0] STATE_IDLE  = 1'b0;
    localparam logic [0:0] STATE_FLUSH = 1'b1;

    function automatic hold_flag_t hold_max(input hold_flag_t a, input hold_flag_t b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_wdt.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_wdt
// Description : Saturating consecutive-hold counter with a sticky timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_wdt #(
    parameter int STALL_TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_hold_active,
    output logic o_stall_timeout
);

    localparam logic [15:0] c_limit = 16'(STALL_TIMEOUT);

    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic        r_timeout;

    // Any hold-free cycle breaks the run and restarts the count.
    always_comb begin
        w_cnt_next = 16'd0;
        if (i_hold_active) begin
            w_cnt_next = (r_cnt == c_limit) ? r_cnt : r_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (i_hold_active && (w_cnt_next == c_limit)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_stall_timeout = r_timeout;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hold/flush controller: merges stall requests,
//               sequences redirects plus bubble cycles, gates interrupts.
//               Optional stall watchdog enabled by PIPE_CTRL_WDT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     jump_flag_i,
    input  logic [31:0]              jump_addr_i,
    input  logic                     int_assert_i,
    input  logic [31:0]              int_addr_i,
    input  logic                     hold_flag_ex_i,
    input  logic                     hold_flag_rib_i,
    input  logic                     hold_flag_clint_i,
    input  logic [INT_BUS-1:0]       int_flag_i,
    output logic [Hold_Flag_Bus-1:0] hold_flag_o,
    output logic                     jump_flag_o,
    output logic [31:0]              jump_addr_o,
    output logic [INT_BUS-1:0]       int_flag_o
`ifdef PIPE_CTRL_WDT_EN
    ,
    output logic                     stall_timeout_o
`endif
);

    localparam bit         c_flush_en   = (FLUSH_CYCLES > 0);
    localparam logic [3:0] c_flush_load = c_flush_en ? 4'(FLUSH_CYCLES - 1) : 4'd0;

    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       w_redirect;
    hold_flag_t w_hold_fsm;
    hold_flag_t w_hold_req;
    hold_flag_t w_hold;

    assign w_redirect = int_assert_i | jump_flag_i;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= STATE_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            STATE_IDLE: begin
                if (w_redirect && c_flush_en) begin
                    w_state_next = STATE_FLUSH;
                    w_cnt_next   = c_flush_load;
                end
            end
            STATE_FLUSH: begin
                if (w_redirect) begin
                    w_cnt_next = c_flush_load;
                end else if (r_cnt == 4'd0) begin
                    w_state_next = STATE_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_next = STATE_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // Output logic: the redirect itself flushes if_id/id_ex, bubbles follow from FLUSH.
    always_comb begin
        w_hold_fsm = (r_state == STATE_FLUSH) ? Hold_If : Hold_None;
        w_hold_req = Hold_None;
        if (hold_flag_rib_i) begin
            w_hold_req = Hold_Pc;
        end
        if (hold_flag_ex_i || hold_flag_clint_i || w_redirect) begin
            w_hold_req = Hold_Id;
        end
        w_hold = hold_max(w_hold_fsm, w_hold_req);

        hold_flag_o = w_hold;
        jump_flag_o = w_redirect;
        if (int_assert_i) begin
            jump_addr_o = int_addr_i;
        end else if (jump_flag_i) begin
            jump_addr_o = jump_addr_i;
        end else begin
            jump_addr_o = 32'd0;
        end

        if ((r_state == STATE_FLUSH) || w_redirect || (w_hold >= Hold_If)) begin
            int_flag_o = INT_NONE;
        end else begin
            int_flag_o = int_flag_i;
        end
    end

`ifdef PIPE_CTRL_WDT_EN
    pipe_ctrl_wdt #(
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_wdt (
        .clk             (clk),
        .rst             (rst),
        .i_hold_active   (w_hold != Hold_None),
        .o_stall_timeout (stall_timeout_o)
    );
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^16'(STALL_TIMEOUT);
`endif

endmodule
`default_nettype wire
